concat_engine_n: RTL and testbench

//   Last-dimension concat of NUM_SRC row-major INT8 tensors in SRAM0. Next generation of the 2-input concat.
//   Per row r, the source segments s=0..NUM_SRC-1 are copied back-to-back into one dst row.

---
 rtl/graph_isa_pkg.sv | 14 +
 rtl/concat_wr_delay.sv | 48 ++++
 rtl/concat_engine_n.sv | 179 +++++++++++++++++
 tb/tb_concat_engine_n.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_isa_pkg.sv
// Shared graph-engine ISA definitions.
// Holds the concat engine's source limit and FSM state type.
package graph_isa_pkg;

  localparam int CONCAT_MAX_SRC = 8;

  typedef enum logic [1:0] {
    CN_IDLE,
    CN_ISSUE,
    CN_DRAIN,
    CN_DONE
  } cn_state_t;

endpackage

// File: rtl/concat_wr_delay.sv
// Write-address delay line for the concat engine.
// Pairs each issued read with its destination address for RD_LAT cycles.
module concat_wr_delay #(
  parameter int AW    = 16,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  output logic          pop,
  output logic [AW-1:0] pop_addr,
  output logic          pending
);

  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    addr [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr[0] <= push_addr;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      addr[i] <= addr[i-1];
    end
  end

  assign pop      = vld[DEPTH-1];
  assign pop_addr = addr[DEPTH-1];

  // Entries that will still be in flight after the current output is consumed.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
      pending = pending | vld[i];
    end
  end

endmodule

// File: rtl/concat_engine_n.sv
// NUM_SRC-input last-dimension concat engine over SRAM0, one byte per cycle.
// Reads stream from per-source row pointers; writes follow RD_LAT cycles later.
module concat_engine_n
  import graph_isa_pkg::*;
#(
  parameter int SRAM0_AW = 16,
  parameter int NUM_SRC  = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [16*NUM_SRC-1:0] cmd_src_base,
  input  logic [16*NUM_SRC-1:0] cmd_src_row_len,
  input  logic [15:0]           cmd_dst_base,
  input  logic [15:0]           cmd_num_rows,
  output logic                  sram_rd_en,
  output logic [SRAM0_AW-1:0]   sram_rd_addr,
  input  logic [7:0]            sram_rd_data,
  output logic                  sram_wr_en,
  output logic [SRAM0_AW-1:0]   sram_wr_addr,
  output logic [7:0]            sram_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int AW = SRAM0_AW;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [SW-1:0] SEG_LAST = SW'(NUM_SRC - 1);

  cn_state_t state, state_nx;

  logic [15:0]   len_q [NUM_SRC];
  logic [15:0]   pre_q [NUM_SRC];
  logic [AW-1:0] ptr_q [NUM_SRC];
  logic [AW-1:0] dst_ptr_q;
  logic [15:0]   stride_q;
  logic [15:0]   rows_q;
  logic [15:0]   row_q;
  logic [15:0]   byte_q;
  logic [SW-1:0] seg_q;

  logic [15:0]   pre_c [NUM_SRC];
  logic [15:0]   stride_c;
  logic          accept;
  logic          issue_rd;
  logic [15:0]   cur_len;
  logic          cur_zero;
  logic          seg_end;
  logic          row_end;
  logic          last_row;
  logic [AW-1:0] rd_addr_c;
  logic [AW-1:0] wr_addr_c;
  logic          dly_valid;
  logic [AW-1:0] dly_addr;
  logic          dly_pending;

  // Running prefix of row lengths; the final sum is the dst row stride.
  always_comb begin
    stride_c = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pre_c[i] = stride_c;
      stride_c = stride_c + cmd_src_row_len[16*i +: 16];
    end
  end

  assign cmd_ready = (state == CN_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign cur_len   = len_q[seg_q];
  assign cur_zero  = (cur_len == '0);
  assign seg_end   = cur_zero || (byte_q == cur_len - 16'd1);
  assign row_end   = seg_end && (seg_q == SEG_LAST);
  assign last_row  = (row_q == rows_q - 16'd1);

  assign rd_addr_c = ptr_q[seg_q] + AW'(byte_q);
  assign wr_addr_c = dst_ptr_q + AW'(pre_q[seg_q]) + AW'(byte_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CN_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue_rd = 1'b0;
    case (state)
      CN_IDLE: begin
        if (accept) begin
          state_nx = (cmd_num_rows == '0 || stride_c == '0) ? CN_DONE : CN_ISSUE;
        end
      end
      CN_ISSUE: begin
        issue_rd = !cur_zero;
        if (row_end && last_row) begin
          state_nx = CN_DRAIN;
        end
      end
      CN_DRAIN: begin
        if (!dly_pending) begin
          state_nx = CN_DONE;
        end
      end
      CN_DONE: state_nx = CN_IDLE;
      default: state_nx = CN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q     <= '0;
      byte_q    <= '0;
      row_q     <= '0;
      rows_q    <= '0;
      stride_q  <= '0;
      dst_ptr_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        len_q[i] <= '0;
        pre_q[i] <= '0;
        ptr_q[i] <= '0;
      end
    end else if (accept) begin
      seg_q     <= '0;
      byte_q    <= '0;
      row_q     <= '0;
      rows_q    <= cmd_num_rows;
      stride_q  <= stride_c;
      dst_ptr_q <= AW'(cmd_dst_base);
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        len_q[i] <= cmd_src_row_len[16*i +: 16];
        pre_q[i] <= pre_c[i];
        ptr_q[i] <= AW'(cmd_src_base[16*i +: 16]);
      end
    end else if (state == CN_ISSUE) begin
      if (!seg_end) begin
        byte_q <= byte_q + 16'd1;
      end else begin
        byte_q <= '0;
        if (seg_q == SEG_LAST) begin
          // Row boundary: every pointer steps by its own row length, no multiply.
          seg_q     <= '0;
          row_q     <= row_q + 16'd1;
          dst_ptr_q <= dst_ptr_q + AW'(stride_q);
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ptr_q[i] <= ptr_q[i] + AW'(len_q[i]);
          end
        end else begin
          seg_q <= seg_q + 1'b1;
        end
      end
    end
  end

  concat_wr_delay #(
    .AW    (AW),
    .DEPTH (RD_LAT)
  ) u_wr_delay (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_rd),
    .push_addr (wr_addr_c),
    .pop       (dly_valid),
    .pop_addr  (dly_addr),
    .pending   (dly_pending)
  );

  assign sram_rd_en   = issue_rd && !rst;
  assign sram_rd_addr = sram_rd_en ? rd_addr_c : '0;
  assign sram_wr_en   = dly_valid && !rst;
  assign sram_wr_addr = sram_wr_en ? dly_addr : '0;
  assign sram_wr_data = sram_wr_en ? sram_rd_data : '0;
  assign busy         = (state != CN_IDLE);
  assign done         = (state == CN_DONE) && !rst;

endmodule

// File: tb/tb_concat_engine_n.sv
// Bench for concat_engine_n: three DUT configurations, each with an SRAM model
// and a per-cycle schedule model derived from row/segment arithmetic.
module tb_concat_engine_n;

  logic clk;
  int   checks = 0;
  int   passes = 0;
  bit   lane_fin [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int NS = (g == 1) ? 4 : 2;
    localparam int RL = (g == 2) ? 3 : 1;

    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [16*NS-1:0]  src_base;
    logic [16*NS-1:0]  row_len;
    logic [15:0]       dst_base;
    logic [15:0]       num_rows;
    logic              rd_en;
    logic [15:0]       rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [15:0]       wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;

    logic [7:0] mem [0:65535];
    logic [7:0] rdq [RL];

    bit         e_rd  [128];
    bit         e_wr  [128];
    logic [15:0] e_rda [128];
    logic [15:0] e_wra [128];
    logic [7:0]  e_wrd [128];
    int T, k, wr_seen, first_wr, done_at;
    bit active;

    concat_engine_n #(
      .SRAM0_AW (16),
      .NUM_SRC  (NS),
      .RD_LAT   (RL)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_src_base    (src_base),
      .cmd_src_row_len (row_len),
      .cmd_dst_base    (dst_base),
      .cmd_num_rows    (num_rows),
      .sram_rd_en      (rd_en),
      .sram_rd_addr    (rd_addr),
      .sram_rd_data    (rd_data),
      .sram_wr_en      (wr_en),
      .sram_wr_addr    (wr_addr),
      .sram_wr_data    (wr_data),
      .busy            (busy),
      .done            (done)
    );

    // Source content: every byte holds the low byte of its own address.
    initial begin
      for (int i = 0; i < 65536; i++) mem[i] <= i[7:0];
    end

    always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rdq[0] <= rd_en ? mem[rd_addr] : 8'hEE;
      for (int i = 1; i < RL; i++) rdq[i] <= rdq[i-1];
    end
    assign rd_data = rdq[RL-1];

    // Expected schedule: byte x of segment s in row r reads base[s]+r*len[s]+x
    // and lands at dst+r*stride+prefix[s]+x, RL cycles later; empty segments cost one cycle.
    task automatic build(input logic [16*NS-1:0] b, input logic [16*NS-1:0] l,
                         input logic [15:0] d, input logic [15:0] n);
      logic [15:0] pre [NS];
      logic [15:0] st, ln, sa;
      int c;
      for (int i = 0; i < 128; i++) begin
        e_rd[i] = 0; e_wr[i] = 0; e_rda[i] = '0; e_wra[i] = '0; e_wrd[i] = '0;
      end
      st = '0;
      for (int s = 0; s < NS; s++) begin
        pre[s] = st;
        st = st + l[16*s +: 16];
      end
      c = 1;
      if (n != 0 && st != 0) begin
        for (int r = 0; r < int'(n); r++) begin
          for (int s = 0; s < NS; s++) begin
            ln = l[16*s +: 16];
            if (ln == 0) c++;
            else begin
              for (int x = 0; x < int'(ln); x++) begin
                sa = b[16*s +: 16] + 16'(r) * ln + 16'(x);
                e_rd[c] = 1; e_rda[c] = sa;
                e_wr[c+RL] = 1;
                e_wra[c+RL] = d + 16'(r) * st + pre[s] + 16'(x);
                e_wrd[c+RL] = sa[7:0];
                c++;
              end
            end
          end
        end
        T = c + RL;
      end else begin
        T = 1;
      end
    endtask

    always @(negedge clk) begin
      if (active) begin
        k = k + 1;
        check($sformatf("L%0d.%0d rd_en", g, k), 32'(rd_en), 32'(e_rd[k]));
        if (e_rd[k]) check($sformatf("L%0d.%0d rd_addr", g, k), 32'(rd_addr), 32'(e_rda[k]));
        check($sformatf("L%0d.%0d wr_en", g, k), 32'(wr_en), 32'(e_wr[k]));
        if (e_wr[k]) begin
          check($sformatf("L%0d.%0d wr_addr", g, k), 32'(wr_addr), 32'(e_wra[k]));
          check($sformatf("L%0d.%0d wr_data", g, k), 32'(wr_data), 32'(e_wrd[k]));
        end
        check($sformatf("L%0d.%0d done", g, k), 32'(done), 32'(k == T));
        check($sformatf("L%0d.%0d busy", g, k), 32'(busy), 32'(k <= T));
        check($sformatf("L%0d.%0d cmd_ready", g, k), 32'(cmd_ready), 32'(k > T));
        if (wr_en) begin
          wr_seen++;
          if (first_wr == 0) first_wr = k;
        end
        if (done) done_at = k;
        if (k >= T + 1) active = 0;
      end
    end

    task automatic check_idle(input string tag);
      check({tag, " cmd_ready"}, 32'(cmd_ready), 1);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " rd_en"}, 32'(rd_en), 0);
      check({tag, " wr_en"}, 32'(wr_en), 0);
      check({tag, " done"}, 32'(done), 0);
    endtask

    task automatic launch(input logic [16*NS-1:0] b, input logic [16*NS-1:0] l,
                          input logic [15:0] d, input logic [15:0] n);
      build(b, l, d, n);
      @(posedge clk); #1;
      src_base = b; row_len = l; dst_base = d; num_rows = n; cmd_valid = 1;
      #1 check($sformatf("L%0d ready_pre_accept", g), 32'(cmd_ready), 1);
      @(posedge clk); #1;
      k = 0; wr_seen = 0; first_wr = 0; done_at = 0; active = 1;
    endtask

    task automatic finish_job(input bit hold);
      if (hold) begin
        dst_base = 16'h7777; num_rows = 16'd9;
        repeat (T - 1) @(posedge clk);
        #1;
      end
      cmd_valid = 0;
      for (int i = 0; i < 300 && active; i++) @(posedge clk);
      check($sformatf("L%0d job_timeout", g), 32'(active), 0);
      active = 0;
    endtask

    task automatic check_dst(input string tag, input logic [15:0] base,
                             input logic [127:0] bytes, input int n);
      logic [15:0] a;
      for (int i = 0; i < n; i++) begin
        a = base + 16'(i);
        check($sformatf("%s byte%0d", tag, i), 32'(mem[a]), 32'(bytes[8*i +: 8]));
      end
    endtask

    task automatic do_reset();
      rst = 1; cmd_valid = 0; src_base = '0; row_len = '0; dst_base = '0; num_rows = '0;
      repeat (3) @(posedge clk);
      #1 check_idle($sformatf("L%0d reset", g));
      rst = 0;
    endtask

    if (g == 0) begin : g_t0
      initial begin
        do_reset();
        // lens {3,2}, 2 rows
        launch({16'h0230, 16'h0110}, {16'd2, 16'd3}, 16'h1000, 16'd2);
        finish_job(0);
        check("t1 done_at", 32'(done_at), 12);
        check("t1 writes", 32'(wr_seen), 10);
        check_dst("t1 dst", 16'h1000, 128'h33_32_15_14_13_31_30_12_11_10, 10);
        // no-op commands
        launch({16'h0230, 16'h0110}, {16'd2, 16'd3}, 16'h1100, 16'd0);
        finish_job(0);
        check("t4a done_at", 32'(done_at), 1);
        check("t4a writes", 32'(wr_seen), 0);
        launch({16'h0230, 16'h0110}, {16'd0, 16'd0}, 16'h1100, 16'd5);
        finish_job(0);
        check("t4b done_at", 32'(done_at), 1);
        // reset in the middle of row 1
        launch({16'h0230, 16'h0110}, {16'd2, 16'd3}, 16'h2000, 16'd3);
        cmd_valid = 0;
        repeat (6) @(posedge clk);
        #1 active = 0; rst = 1;
        #1 check("t5 wr_en_in_rst", 32'(wr_en), 0);
        check("t5 rd_en_in_rst", 32'(rd_en), 0);
        @(posedge clk); #1 rst = 0;
        #1 check_idle("t5 after_rst");
        launch({16'h0340, 16'h0300}, {16'd2, 16'd3}, 16'h3000, 16'd3);
        finish_job(0);
        check("t5 done_at", 32'(done_at), 17);
        check("t5 writes", 32'(wr_seen), 15);
        check_dst("t5 dst", 16'h3000, 128'h45_44_08_07_06_43_42_05_04_03_41_40_02_01_00, 15);
        // dst wrap, cmd_valid held through the job
        launch({16'h0450, 16'h0400}, {16'd2, 16'd2}, 16'hFFFE, 16'd1);
        finish_job(1);
        check("t6 done_at", 32'(done_at), 6);
        check_dst("t6 dst", 16'hFFFE, 128'h51_50_01_00, 4);
        lane_fin[0] = 1;
      end
    end else if (g == 1) begin : g_t1
      initial begin
        do_reset();
        // lens {1,0,2,0}, 3 rows
        launch({16'h0800, 16'h0200, 16'h0700, 16'h0180},
               {16'd0, 16'd2, 16'd0, 16'd1}, 16'h4000, 16'd3);
        finish_job(0);
        check("t2 done_at", 32'(done_at), 17);
        check("t2 writes", 32'(wr_seen), 9);
        check_dst("t2 dst", 16'h4000, 128'h05_04_82_03_02_81_01_00_80, 9);
        lane_fin[1] = 1;
      end
    end else begin : g_t2
      initial begin
        do_reset();
        // RD_LAT=3, lens {4,4}, 1 row
        launch({16'h0240, 16'h0120}, {16'd4, 16'd4}, 16'h5000, 16'd1);
        finish_job(0);
        check("t3 done_at", 32'(done_at), 12);
        check("t3 writes", 32'(wr_seen), 8);
        check("t3 first_wr", 32'(first_wr), 4);
        check_dst("t3 dst", 16'h5000, 128'h43_42_41_40_23_22_21_20, 8);
        lane_fin[2] = 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (lane_fin[0] && lane_fin[1] && lane_fin[2]) break;
    end
    check("all_lanes_finished", {29'd0, lane_fin[2], lane_fin[1], lane_fin[0]}, 7);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
